// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI request arbiter.
package spi_arb_pkg;

  localparam int SPI_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  // Width of a requester index; never narrower than one bit.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_req_arbiter_if.sv
// Requester and SPI-controller signal bundle of spi_req_arbiter.
// slave = arbiter side, master = requesters plus controller side.
interface spi_req_arbiter_if
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
);

  localparam int ID_W = id_w(NUM_REQ);

  // requester side
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ-1:0]            req_wr;
  logic [SPI_DATA_W*NUM_REQ-1:0] req_addr;
  logic [SPI_DATA_W*NUM_REQ-1:0] req_din;
  logic [NUM_REQ-1:0]            ack;
  logic [SPI_DATA_W-1:0]         rsp_dout;
  logic                          rsp_err;
  logic [ID_W-1:0]               grant_id;
  logic                          busy;

  // controller side
  logic                  spi_start;
  logic                  spi_wr;
  logic [SPI_DATA_W-1:0] spi_addr;
  logic [SPI_DATA_W-1:0] spi_din;
  logic                  spi_done;
  logic                  spi_err;
  logic [SPI_DATA_W-1:0] spi_dout;

  modport master (
    output req, req_wr, req_addr, req_din,
    output spi_done, spi_err, spi_dout,
    input  ack, rsp_dout, rsp_err, grant_id, busy,
    input  spi_start, spi_wr, spi_addr, spi_din
  );

  modport slave (
    input  req, req_wr, req_addr, req_din,
    input  spi_done, spi_err, spi_dout,
    output ack, rsp_dout, rsp_err, grant_id, busy,
    output spi_start, spi_wr, spi_addr, spi_din
  );

endinterface

// File: rtl/spi_rr_pick.sv
// Combinational round-robin picker: first set req bit at or after last_grant+1.
module spi_rr_pick #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = spi_arb_pkg::id_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_grant,
  output logic [ID_W-1:0]    grant,
  output logic               valid
);

  int idx;

  // NOTE: every output gets a default before the loop so no path leaves it
  // unassigned; a missing default would infer a latch.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = 0;
    // Scan farthest offset first so the nearest requester is the last write.
    for (int off = NUM_REQ; off >= 1; off--) begin
      idx = int'(last_grant) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req[idx]) begin
        grant = ID_W'(idx);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter sharing one SPI controller among NUM_REQ requesters.
// Optional WAIT timeout enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_req_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic               clk,
  input  logic               rst,
  spi_req_arbiter_if.slave   bus
);

  localparam int ID_W = id_w(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1) begin : g_bad_param
    $error("spi_req_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYC >= 1");
  end

  arb_state_e            state;
  arb_state_e            state_nxt;
  logic [ID_W-1:0]       last_grant;
  logic [ID_W-1:0]       grant_id;
  logic                  spi_wr;
  logic [SPI_DATA_W-1:0] spi_addr;
  logic [SPI_DATA_W-1:0] spi_din;
  logic [SPI_DATA_W-1:0] rsp_dout;
  logic                  rsp_err;

  logic [ID_W-1:0]       pick_id;
  logic                  pick_valid;
  logic                  grant_now;
  logic                  finish_now;
  logic                  timeout;

  spi_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req        (bus.req),
    .last_grant (last_grant),
    .grant      (pick_id),
    .valid      (pick_valid)
  );

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] wait_cnt;

  // Counts WAIT cycles; leaving WAIT on the last allowed cycle keeps it in range.
  always_ff @(posedge clk) begin
    if (rst || state != WAIT) wait_cnt <= '0;
    else                      wait_cnt <= wait_cnt + 1'b1;
  end

  assign timeout = (state == WAIT) && !bus.spi_done &&
                   (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
  assign timeout = 1'b0;
`endif

  assign grant_now  = (state == IDLE) && pick_valid;
  assign finish_now = (state == WAIT) && (bus.spi_done || timeout);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (pick_valid) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (bus.spi_done || timeout) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Transaction fields are frozen at grant; later requester changes are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= ID_W'(NUM_REQ - 1);
      grant_id   <= '0;
      spi_wr     <= 1'b0;
      spi_addr   <= '0;
      spi_din    <= '0;
      rsp_dout   <= '0;
      rsp_err    <= 1'b0;
    end else begin
      if (grant_now) begin
        grant_id <= pick_id;
        spi_wr   <= bus.req_wr[pick_id];
        spi_addr <= bus.req_addr[SPI_DATA_W*pick_id +: SPI_DATA_W];
        spi_din  <= bus.req_din[SPI_DATA_W*pick_id +: SPI_DATA_W];
      end
      if (finish_now) begin
        if (bus.spi_done) begin
          rsp_err  <= bus.spi_err;
          rsp_dout <= (bus.spi_err || spi_wr) ? '0 : bus.spi_dout;
        end else begin
          rsp_err  <= 1'b1;
          rsp_dout <= '0;
        end
      end
      if (state == RESP) last_grant <= grant_id;
    end
  end

  always_comb begin
    bus.ack = '0;
    if (state == RESP) bus.ack = NUM_REQ'(1) << grant_id;
  end

  assign bus.spi_start = (state == ISSUE);
  assign bus.busy      = (state != IDLE);
  assign bus.grant_id  = grant_id;
  assign bus.spi_wr    = spi_wr;
  assign bus.spi_addr  = spi_addr;
  assign bus.spi_din   = spi_din;
  assign bus.rsp_dout  = rsp_dout;
  assign bus.rsp_err   = rsp_err;

endmodule

// File: tb/tb_spi_req_arbiter.sv
// Randomized bench for spi_req_arbiter against a transaction-level round-robin model.
module tb_spi_req_arbiter;
  import spi_arb_pkg::*;

  localparam int N  = 4;
  localparam int TO = 16;
`ifdef SPI_ARB_TIMEOUT_EN
  localparam int DLY_LONG = TO - 2;
`else
  localparam int DLY_LONG = 19;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_req_arbiter_if #(.NUM_REQ(N)) bus ();

  spi_req_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [N-1:0] req_v, wr_v;
  logic [7:0]   addr_v [N];
  logic [7:0]   din_v  [N];
  int           last_g;
  int           n_vec = 0;
  int           n_err = 0;
  int           gid;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_reqs();
    bus.req    = req_v;
    bus.req_wr = wr_v;
    for (int i = 0; i < N; i++) begin
      bus.req_addr[8*i +: 8] = addr_v[i];
      bus.req_din[8*i +: 8]  = din_v[i];
    end
  endtask

  function automatic int rr_winner(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++)
      if (r[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  task automatic raise(input int i, input logic wr, input logic [7:0] a, input logic [7:0] d);
    req_v[i]  = 1'b1;
    wr_v[i]   = wr;
    addr_v[i] = a;
    din_v[i]  = d;
  endtask

  task automatic raise_rand(input int i);
    raise(i, 1'($urandom), 8'($urandom), 8'($urandom));
  endtask

  // Entered at a negedge with the DUT idle; req_v must be nonzero.
  // dly<0 means no spi_done (timeout build only). mode: 0 drop winner and
  // add random requests, 1 keep all, 2 clear all.
  task automatic run_txn(input int dly, input bit stray, input bit chg, input bit drop,
                         input bit err, input logic [7:0] dout, input int mode,
                         output int gid_seen);
    int         w;
    logic       e_wr, e_err;
    logic [7:0] e_addr, e_din, e_dout;
    drive_reqs();
    check("idle_busy", bus.busy, 0);
    check("idle_ack", bus.ack, 0);
    check("idle_start", bus.spi_start, 0);
    w      = rr_winner(req_v, last_g);
    e_wr   = wr_v[w];
    e_addr = addr_v[w];
    e_din  = din_v[w];
    @(negedge clk);
    gid_seen = int'(bus.grant_id);
    check("spi_start", bus.spi_start, 1);
    check("grant_id", bus.grant_id, w);
    check("spi_wr", bus.spi_wr, e_wr);
    check("spi_addr", bus.spi_addr, e_addr);
    check("spi_din", bus.spi_din, e_din);
    check("issue_busy", bus.busy, 1);
    if (stray) begin
      bus.spi_done = 1'b1;
      bus.spi_err  = 1'b1;
      bus.spi_dout = 8'($urandom);
    end
    @(negedge clk);
    bus.spi_done = 1'b0;
    check("wait_ack", bus.ack, 0);
    check("wait_start", bus.spi_start, 0);
    check("wait_busy", bus.busy, 1);
    if (chg) begin
      addr_v[w] = ~e_addr;
      din_v[w]  = ~e_din;
      wr_v[w]   = ~e_wr;
    end
    if (drop) req_v[w] = 1'b0;
    drive_reqs();
    e_err  = err;
    e_dout = (err || e_wr) ? 8'h00 : dout;
`ifdef SPI_ARB_TIMEOUT_EN
    if (dly < 0) begin
      repeat (TO - 1) begin
        @(negedge clk);
        check("to_wait_ack", bus.ack, 0);
      end
      e_err  = 1'b1;
      e_dout = 8'h00;
      @(negedge clk);
    end else
`endif
    begin
      repeat (dly) begin
        @(negedge clk);
        check("wait_ack", bus.ack, 0);
        check("hold_addr", bus.spi_addr, e_addr);
      end
      bus.spi_done = 1'b1;
      bus.spi_err  = err;
      bus.spi_dout = dout;
      @(negedge clk);
      bus.spi_done = 1'b0;
      bus.spi_err  = 1'($urandom);
      bus.spi_dout = 8'($urandom);
    end
    check("ack", bus.ack, 1 << w);
    check("rsp_dout", bus.rsp_dout, e_dout);
    check("rsp_err", bus.rsp_err, e_err);
    check("resp_busy", bus.busy, 1);
    check("resp_addr", bus.spi_addr, e_addr);
    last_g = w;
    case (mode)
      0: begin
        req_v[w] = 1'b0;
        for (int i = 0; i < N; i++)
          if (!req_v[i] && $urandom_range(0, 2) == 0) raise_rand(i);
      end
      1: req_v[w] = 1'b1;
      default: req_v = '0;
    endcase
    drive_reqs();
    @(negedge clk);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    req_v = '0;
    wr_v  = '0;
    for (int i = 0; i < N; i++) begin
      addr_v[i] = '0;
      din_v[i]  = '0;
    end
    drive_reqs();
    bus.spi_done = 1'b0;
    bus.spi_err  = 1'b0;
    bus.spi_dout = '0;
    rst = 1'b1;
    last_g = N - 1;
    repeat (3) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_ack", bus.ack, 0);
    check("rst_start", bus.spi_start, 0);
    check("rst_gid", bus.grant_id, 0);
    check("rst_dout", bus.rsp_dout, 0);
    check("rst_err", bus.rsp_err, 0);
    check("rst_addr", {bus.spi_wr, bus.spi_addr, bus.spi_din}, 0);
    rst = 1'b0;

    // Stray done while idle must be ignored.
    @(negedge clk);
    bus.spi_done = 1'b1;
    @(negedge clk);
    bus.spi_done = 1'b0;
    check("stray_busy", bus.busy, 0);
    check("stray_ack", bus.ack, 0);

    // Read from requester 0, done 20 cycles after start.
    raise(0, 1'b0, 8'h05, 8'h00);
    run_txn(DLY_LONG, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 2, gid);

    // Write from requester 2 that completes with an error.
    raise(2, 1'b1, 8'h40, 8'h3C);
    run_txn(3, 1'b0, 1'b0, 1'b0, 1'b1, 8'h77, 2, gid);

    // Requester 1 changes its inputs and drops req while in flight.
    raise(1, 1'b0, 8'h21, 8'h12);
    run_txn(4, 1'b1, 1'b1, 1'b1, 1'b0, 8'h5A, 2, gid);

    // Reset during WAIT drops the transaction without an ack.
    req_v = 4'b0110;
    drive_reqs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", bus.busy, 0);
    check("midrst_ack", bus.ack, 0);
    check("midrst_gid", bus.grant_id, 0);
    check("midrst_fields", {bus.spi_wr, bus.spi_addr, bus.spi_din}, 0);
    rst = 1'b0;
    last_g = N - 1;
    req_v = '0;
    raise(3, 1'b0, 8'h33, 8'h00);
    run_txn(1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hC3, 2, gid);
    check("after_rst_gid", gid, 3);

    // All requesters held: strict rotation 0,1,2,3,0,1,2,3.
    for (int i = 0; i < N; i++) raise_rand(i);
    for (int t = 0; t < 8; t++) begin
      run_txn($urandom_range(0, 3), 1'b0, 1'b0, 1'b0, 1'($urandom),
              8'($urandom), (t == 7) ? 2 : 1, gid);
      check("rr_order", gid, t % N);
    end

`ifdef SPI_ARB_TIMEOUT_EN
    raise(1, 1'b0, 8'h99, 8'h00);
    run_txn(-1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 2, gid);
`endif

    // Randomized traffic.
    for (int t = 0; t < 150; t++) begin
      if (req_v == '0) raise_rand($urandom_range(0, N - 1));
      run_txn($urandom_range(0, 6), $urandom_range(0, 3) == 0,
              1'($urandom), $urandom_range(0, 3) == 0,
              $urandom_range(0, 3) == 0, 8'($urandom),
              ($urandom_range(0, 4) == 0) ? 1 : 0, gid);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
